// File: rtl/ifmap_buffer_pkg.sv
// rtl/ifmap_buffer_pkg.sv - shared types, sizes and the layer row-count table for ifmap_buffer
package ifmap_buffer_pkg;

    localparam int ROW_BYTES = 256;
    localparam int ROW_BITS  = ROW_BYTES * 8;
    localparam int MAX_ROWS  = 35;
    localparam int PTR_W     = 6;

    typedef enum logic [1:0] {
        CONV1 = 2'd0,
        CONV2 = 2'd1,
        CONV3 = 2'd2,
        FC    = 2'd3
    } LAYER_TYPE;

    typedef struct packed {
        logic [ROW_BITS-1:0] data;
        logic                layer_end;
    } DECOMPRESS_FIFO_PACKET;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    // Number of rows that make up one tile for each layer type.
    function automatic logic [PTR_W-1:0] rows_needed(input LAYER_TYPE lt);
        logic [PTR_W-1:0] n;
        case (lt)
            CONV1:   n = 6'd35;
            CONV2:   n = 6'd7;
            CONV3:   n = 6'd3;
            FC:      n = 6'd1;
            default: n = 6'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ifmap_buffer_if.sv
// rtl/ifmap_buffer_if.sv - control, decompressor and tile-output signals of ifmap_buffer
//   master: drives start/layer_type_in/decompressed_fifo_packet/decompressor_ack/free_ifmap_buffer
//   slave : drives global_buffer_req/ifmap_data/ifmap_data_valid/ifmap_data_change
interface ifmap_buffer_if;
    import ifmap_buffer_pkg::*;

    logic                                   start;
    LAYER_TYPE                              layer_type_in;
    DECOMPRESS_FIFO_PACKET                  decompressed_fifo_packet;
    logic                                   decompressor_ack;
    logic                                   free_ifmap_buffer;
    logic                                   global_buffer_req;
    logic [MAX_ROWS-1:0][ROW_BITS-1:0]      ifmap_data;
    logic                                   ifmap_data_valid;
    logic                                   ifmap_data_change;

    modport master (
        output start,
        output layer_type_in,
        output decompressed_fifo_packet,
        output decompressor_ack,
        output free_ifmap_buffer,
        input  global_buffer_req,
        input  ifmap_data,
        input  ifmap_data_valid,
        input  ifmap_data_change
    );

    modport slave (
        input  start,
        input  layer_type_in,
        input  decompressed_fifo_packet,
        input  decompressor_ack,
        input  free_ifmap_buffer,
        output global_buffer_req,
        output ifmap_data,
        output ifmap_data_valid,
        output ifmap_data_change
    );

endinterface

// File: rtl/ifmap_buffer.sv
// rtl/ifmap_buffer.sv - collects decompressed rows into a 35-row input-feature-map tile
//   clk : single rising-edge clock
//   rst : synchronous active-high reset
//   bus : ifmap_buffer_if.slave (start/layer select, row packets + ack, tile release,
//         row request, 35-row tile output with valid and new-tile pulse)
module ifmap_buffer
    import ifmap_buffer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    ifmap_buffer_if.slave  bus
);

    state_t                              state_q, state_d;
    LAYER_TYPE                           layer_q, layer_d;
    logic [PTR_W-1:0]                    wr_ptr_q, wr_ptr_d;
    logic                                end_q, end_d;
    logic                                change_q, change_d;
    logic [MAX_ROWS-1:0][ROW_BITS-1:0]   rows_q, rows_d;

    logic [PTR_W-1:0]                    need;
    logic                                wr_en;
    logic                                last_write;

    assign need       = rows_needed(layer_q);
    assign wr_en      = (state_q == FILL) && bus.decompressor_ack;
    assign last_write = wr_en && ((wr_ptr_q + 6'd1) == need);

    // State register and all other storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            layer_q  <= CONV1;
            wr_ptr_q <= '0;
            end_q    <= 1'b0;
            change_q <= 1'b0;
            rows_q   <= '0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            wr_ptr_q <= wr_ptr_d;
            end_q    <= end_d;
            change_q <= change_d;
            rows_q   <= rows_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start)             state_d = FILL;
            FILL: if (last_write)            state_d = FULL;
            FULL: if (bus.free_ifmap_buffer) state_d = end_q ? IDLE : FILL;
            default:                         state_d = IDLE;
        endcase
    end

    // Datapath next values: layer latch, write pointer, end flag, row storage.
    always_comb begin
        layer_d  = layer_q;
        wr_ptr_d = wr_ptr_q;
        end_d    = end_q;
        change_d = 1'b0;
        rows_d   = rows_q;

        if ((state_q == IDLE) && bus.start) begin
            // Clearing every row here is what keeps rows beyond the tile depth at zero.
            layer_d  = bus.layer_type_in;
            wr_ptr_d = '0;
            end_d    = 1'b0;
            rows_d   = '0;
        end

        if (wr_en) begin
            for (int i = 0; i < MAX_ROWS; i++) begin
                if (wr_ptr_q == PTR_W'(i)) begin
                    rows_d[i] = bus.decompressed_fifo_packet.data;
                end
            end
            wr_ptr_d = wr_ptr_q + 6'd1;
            end_d    = end_q | bus.decompressed_fifo_packet.layer_end;
            change_d = last_write;
        end

        if ((state_q == FULL) && bus.free_ifmap_buffer) begin
            // Old rows are kept; the next tile simply overwrites them in order.
            wr_ptr_d = '0;
            end_d    = 1'b0;
        end
    end

    // Outputs.
    always_comb begin
        bus.global_buffer_req = (state_q == FILL);
        bus.ifmap_data_valid  = (state_q == FULL);
        bus.ifmap_data_change = change_q;
        bus.ifmap_data        = rows_q;
    end

endmodule

// File: tb/tb_ifmap_buffer.sv
// tb/tb_ifmap_buffer.sv - self-checking scoreboard bench for ifmap_buffer
module tb_ifmap_buffer;
    import ifmap_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst;

    ifmap_buffer_if bus ();

    ifmap_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int change_cnt = 0;

    logic [ROW_BITS-1:0] exp_rows [$];
    int                  exp_cnt  [$];

    task automatic check_val(input string tag, input logic [ROW_BITS-1:0] obs, input logic [ROW_BITS-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got low64=%016h want low64=%016h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [ROW_BITS-1:0] fill_byte(input logic [7:0] b);
        return {ROW_BYTES{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input LAYER_TYPE lt);
        bus.start         = 1'b1;
        bus.layer_type_in = lt;
        tick();
        bus.start         = 1'b0;
    endtask

    task automatic send(input logic [ROW_BITS-1:0] d, input logic le, input bit expect_write);
        bus.decompressed_fifo_packet.data      = d;
        bus.decompressed_fifo_packet.layer_end = le;
        bus.decompressor_ack                   = 1'b1;
        if (expect_write) exp_rows.push_back(d);
        tick();
        bus.decompressor_ack = 1'b0;
    endtask

    task automatic release_tile();
        bus.free_ifmap_buffer = 1'b1;
        tick();
        bus.free_ifmap_buffer = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < MAX_ROWS; i++)
            check_val($sformatf("%s_row%0d", tag, i), bus.ifmap_data[i], '0);
    endtask

    // Scoreboard: each new-tile pulse consumes one tile worth of expected rows.
    always @(negedge clk) begin
        int n;
        logic [ROW_BITS-1:0] e;
        if (!rst && bus.ifmap_data_change) begin
            change_cnt++;
            if (exp_cnt.size() == 0) begin
                check_val("sb_unexpected_tile", 1, 0);
            end else begin
                n = exp_cnt.pop_front();
                for (int i = 0; i < MAX_ROWS; i++) begin
                    e = '0;
                    if (i < n && exp_rows.size() > 0) e = exp_rows.pop_front();
                    check_val($sformatf("tile_row%0d", i), bus.ifmap_data[i], e);
                end
            end
        end
    end

    initial begin
        int c0;
        logic [ROW_BITS-1:0] d;

        rst                   = 1'b1;
        bus.start             = 1'b0;
        bus.layer_type_in     = CONV1;
        bus.decompressed_fifo_packet = '0;
        bus.decompressor_ack  = 1'b0;
        bus.free_ifmap_buffer = 1'b0;

        // Reset
        repeat (5) tick();
        check_val("rst_req",    bus.global_buffer_req, 0);
        check_val("rst_valid",  bus.ifmap_data_valid,  0);
        check_val("rst_change", bus.ifmap_data_change, 0);
        check_all_zero("rst");
        rst = 1'b0;
        tick();
        check_val("idle_req", bus.global_buffer_req, 0);
        tick();
        check_val("idle_req2", bus.global_buffer_req, 0);

        // FC: single row
        c0 = change_cnt;
        start_layer(FC);
        check_val("fc_req", bus.global_buffer_req, 1);
        exp_cnt.push_back(1);
        send(fill_byte(8'hAB), 1'b1, 1'b1);
        check_val("fc_req_off", bus.global_buffer_req, 0);
        check_val("fc_valid",   bus.ifmap_data_valid,  1);
        check_val("fc_change",  bus.ifmap_data_change, 1);
        tick();
        check_val("fc_change_pulse", bus.ifmap_data_change, 0);
        check_val("fc_valid_hold",   bus.ifmap_data_valid,  1);
        release_tile();
        check_val("fc_free_valid", bus.ifmap_data_valid, 0);
        check_val("fc_free_req",   bus.global_buffer_req, 0);
        tick();
        check_val("fc_idle_req", bus.global_buffer_req, 0);
        check_val("fc_changes", change_cnt - c0, 1);

        // CONV3 with gaps; free during FILL is ignored
        c0 = change_cnt;
        start_layer(CONV3);
        exp_cnt.push_back(3);
        for (int k = 1; k <= 3; k++) begin
            send(fill_byte(8'(k)), k == 3, 1'b1);
            if (k < 3) begin
                check_val($sformatf("c3_valid_early%0d", k), bus.ifmap_data_valid, 0);
                bus.free_ifmap_buffer = 1'b1;
                tick();
                bus.free_ifmap_buffer = 1'b0;
                check_val($sformatf("c3_req_gap%0d", k), bus.global_buffer_req, 1);
            end
        end
        check_val("c3_valid",  bus.ifmap_data_valid,  1);
        check_val("c3_change", bus.ifmap_data_change, 1);
        tick();
        check_val("c3_change_pulse", bus.ifmap_data_change, 0);
        release_tile();
        check_val("c3_free_req", bus.global_buffer_req, 0);
        check_val("c3_changes", change_cnt - c0, 1);

        // CONV2: two tiles, layer end only on the 14th packet
        c0 = change_cnt;
        start_layer(CONV2);
        exp_cnt.push_back(7);
        for (int i = 0; i < 7; i++) send(fill_byte(8'(8'h10 + i)), 1'b0, 1'b1);
        check_val("c2_t1_valid", bus.ifmap_data_valid, 1);
        release_tile();
        check_val("c2_t1_free_req",   bus.global_buffer_req, 1);
        check_val("c2_t1_free_valid", bus.ifmap_data_valid,  0);
        exp_cnt.push_back(7);
        for (int i = 0; i < 7; i++) begin
            send(fill_byte(8'(8'h20 + i)), i == 6, 1'b1);
            if (i == 3) check_val("c2_retain_row5", bus.ifmap_data[5], fill_byte(8'h15));
        end
        check_val("c2_t2_valid", bus.ifmap_data_valid, 1);
        release_tile();
        check_val("c2_t2_free_req", bus.global_buffer_req, 0);
        tick();
        check_val("c2_idle_req", bus.global_buffer_req, 0);
        check_val("c2_changes", change_cnt - c0, 2);

        // CONV1 full depth; ack and start while FULL are ignored
        start_layer(CONV1);
        exp_cnt.push_back(35);
        for (int i = 0; i < 35; i++) begin
            d = '0;
            d[7:0] = 8'(i);
            send(d, i == 34, 1'b1);
        end
        check_val("c1_valid", bus.ifmap_data_valid, 1);
        bus.start             = 1'b1;
        bus.layer_type_in     = FC;
        bus.decompressed_fifo_packet.data = {ROW_BITS{1'b1}};
        bus.decompressor_ack  = 1'b1;
        repeat (2) tick();
        bus.start            = 1'b0;
        bus.decompressor_ack = 1'b0;
        check_val("c1_full_valid", bus.ifmap_data_valid, 1);
        check_val("c1_full_req",   bus.global_buffer_req, 0);
        check_val("c1_row34_lsb",  bus.ifmap_data[34][7:0], 34);
        for (int i = 0; i < 35; i++) begin
            d = '0;
            d[7:0] = 8'(i);
            check_val($sformatf("c1_stable_row%0d", i), bus.ifmap_data[i], d);
        end
        release_tile();
        check_val("c1_free_req", bus.global_buffer_req, 0);

        // Mid-fill reset overrides start and ack
        start_layer(CONV1);
        for (int i = 0; i < 10; i++) send(fill_byte(8'(8'h40 + i)), 1'b0, 1'b0);
        check_val("mr_req_before", bus.global_buffer_req, 1);
        rst = 1'b1;
        bus.start = 1'b1;
        bus.decompressor_ack = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        bus.decompressor_ack = 1'b0;
        check_val("mr_valid",  bus.ifmap_data_valid,  0);
        check_val("mr_req",    bus.global_buffer_req, 0);
        check_val("mr_change", bus.ifmap_data_change, 0);
        check_all_zero("mr");
        tick();
        check_val("mr_idle_req", bus.global_buffer_req, 0);
        start_layer(CONV3);
        exp_cnt.push_back(3);
        for (int k = 0; k < 3; k++) send(fill_byte(8'(8'h50 + k)), k == 2, 1'b1);
        check_val("mr_refill_valid", bus.ifmap_data_valid, 1);
        release_tile();
        check_val("mr_refill_idle", bus.global_buffer_req, 0);

        tick();
        check_val("sb_leftover", exp_rows.size() + exp_cnt.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifmap_buffer.md
IFMAP_BUFFER -- requirements
Module: ifmap_buffer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1, begin a layer; sampled only in IDLE.
REQ-004 SHALL have port layer_type_in, input, LAYER_TYPE, layer selector; latched when start is accepted.
REQ-005 SHALL have port decompressed_fifo_packet, input, DECOMPRESS_FIFO_PACKET, fields data[2047:0] (one 256-byte row) and layer_end (1 bit).
REQ-006 SHALL have port decompressor_ack, input, 1, packet valid this cycle.
REQ-007 SHALL have port free_ifmap_buffer, input, 1, consumer releases current tile.
REQ-008 SHALL have port global_buffer_req, output, 1, requesting rows.
REQ-009 SHALL have port ifmap_data, output, [34:0][2047:0], row array; row 0 is the first row written.
REQ-010 SHALL have port ifmap_data_valid, output, 1, tile complete and readable.
REQ-011 SHALL have port ifmap_data_change, output, 1, one-cycle pulse when a new tile becomes valid.

Function
REQ-012 SHALL implement states IDLE, FILL, FULL; reset enters IDLE.
REQ-013 IDLE: start=1 SHALL latch layer_type_in, set rows_needed from the package table, clear all 35 rows to 0, clear wr_ptr and end flag, and go to FILL next cycle.
REQ-014 Table: CONV1 = 35 rows, CONV2 = 7 rows, CONV3 = 3 rows, FC = 1 row.
REQ-015 FILL: global_buffer_req SHALL be 1 (combinational from state); it SHALL be 0 in IDLE and FULL.
REQ-016 FILL with decompressor_ack=1 SHALL write data into row[wr_ptr], increment wr_ptr (6-bit), and OR layer_end into the end flag; one row per cycle maximum.
REQ-017 decompressor_ack in IDLE or FULL SHALL be ignored with no write.
REQ-018 When the write making wr_ptr equal rows_needed occurs, the next cycle SHALL be FULL with ifmap_data_valid=1 and ifmap_data_change=1 for exactly that first FULL cycle.
REQ-019 FULL: ifmap_data_valid SHALL stay 1 and row contents SHALL be stable until free_ifmap_buffer=1.
REQ-020 FULL with free_ifmap_buffer=1: ifmap_data_valid SHALL drop next cycle and wr_ptr SHALL reset to 0; if the end flag is set, go to IDLE; else go to FILL, clear the end flag, and retain old rows until they are overwritten.
REQ-021 free_ifmap_buffer outside FULL SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-022 Rows with index >= rows_needed SHALL read 0 on ifmap_data.
REQ-023 ifmap_data SHALL be driven directly from storage registers with no output delay.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE, wr_ptr=0, end flag=0, all rows=0, global_buffer_req=0, ifmap_data_valid=0, ifmap_data_change=0, overriding all other inputs, including mid-FILL.

Structure
REQ-025 Package SHALL hold the LAYER_TYPE enum (2-bit: CONV1, CONV2, CONV3, FC), the DECOMPRESS_FIFO_PACKET struct, ROW_BYTES=256, MAX_ROWS=35, and the rows_needed function.
REQ-026 Block SHALL be one module with no sub-modules; row storage is a flop array with per-row write enable.

Verification
REQ-027 Reset: hold rst=1 for 5 cycles -> all outputs 0; after release, state is IDLE with req=0.
REQ-028 FC layer: start with FC, one ack with data=all 0xAB and layer_end=1 -> req high for 1 cycle, valid=1 and change pulse next cycle, row0=0xAB.., rows1-34=0; free -> IDLE.
REQ-029 CONV3 with gaps: acks on alternate cycles (3 rows: 0x01, 0x02, 0x03) -> valid only after the third ack, rows 0-2 match, change high for exactly 1 cycle.
REQ-030 Multi-tile CONV2: two 7-row tiles, layer_end only on the 14th packet -> first free returns to FILL, second free returns to IDLE; 2 change pulses total.
REQ-031 CONV1 full depth: 35 rows with data[7:0]=row index -> row34 low byte=34; ack while FULL does not alter any row.
REQ-032 Mid-fill reset: rst after 10 of 35 CONV1 rows -> next cycle all rows 0, valid=0, IDLE; start then refills cleanly.
